arb3_mux_sel: RTL and testbench
===============================

# arb3_mux_sel

Registered round-robin arbiter for three requesters. It produces the one-hot grant and the 2-bit `sel` that drives the downstream 3:1 select mux (`sel` 00→a, 01→b, 10→c). The block never issues `sel = 2'b11`, so the mux's default/x branch is unreachable. The grant timing in the tests below is identical in pre- and post-synthesis simulation.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may keep the grant while others request. Legal range 1..255.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  3  request per source; bit i = source i
- `done`  in  1  owner finished; releases the grant at the next edge
- `gnt`  out  3  registered one-hot grant; all zero when idle
- `gnt_valid`  out  1  registered; equals `|gnt`
- `sel`  out  2  registered mux select = index of the current owner; holds the last owner's index while idle
- `hold_cnt`  out  8  registered count of cycles the current owner has held the grant (debug)

## Operation
- Reset values (asynchronous, immediate):
  - `gnt` = 000, `gnt_valid` = 0, `sel` = 00, `hold_cnt` = 0.
  - Internal round-robin pointer `ptr` = 0; `ptr` names the highest-priority source.
- States:
  - IDLE (`gnt` = 0).
  - GRANT (exactly one `gnt` bit set).
- IDLE → GRANT: at any edge where `req` ≠ 0.
  - Winner is the first set bit scanning `ptr`, `ptr`+1, `ptr`+2 (mod 3).
  - `gnt` = onehot(winner), `sel` = winner, `hold_cnt` = 1.
- GRANT, no release condition: `gnt` and `sel` unchanged; `hold_cnt` increments and saturates at 255.
- Release conditions, evaluated at the edge:
  - `req[owner]` = 0, or
  - `done` = 1, or
  - `hold_cnt` ≥ `MAX_HOLD` and another source is requesting.
- On release:
  - `ptr` ← (owner+1) mod 3.
  - Re-arbitrate in the same edge over `req`, with the owner's bit masked if release was caused by `done` or `MAX_HOLD`.
  - Any winner → stay in GRANT with the new owner, `hold_cnt` = 1. This gives back-to-back grants with no idle bubble.
  - No winner → IDLE, `gnt` = 0, `sel` holds.
- `hold_cnt` ≥ `MAX_HOLD` with no other requester: owner keeps the grant, `hold_cnt` reloads to 1.
- `sel` changes only together with a new grant. It is never 11 and never changes while `gnt_valid` = 0.
- Index arithmetic is mod 3 on a 2-bit value: 2+1 wraps to 0, never 3.
- Synthesis:
  - Arbitration scan uses a `unique case` on `ptr` with a `default` branch that assigns 0.
  - Illegal `ptr`/`sel` = 11 recovers to 0 at the next edge.
  - An assertion flags `sel` = 11 and `$countones(gnt)` > 1.

## Timing
- Grant latency: 1 cycle. A `req` asserted before edge n is reflected in `gnt`/`sel` after edge n.
- Release latency: 1 cycle. `req[owner]` deassert or `done` sampled at edge n moves `gnt` at edge n.
- Hold-limit preemption takes effect at the edge where `hold_cnt` = `MAX_HOLD` is sampled with a competing request, so one owner holds at most `MAX_HOLD` cycles.
- Simultaneous requests are resolved purely by `ptr`. `done` in the same cycle as a new `req` from the owner still releases.
- Reset mid-grant: outputs return to reset values immediately, asynchronously. The first grant after `rst_n` rises occurs at the first edge with `req` ≠ 0, giving source 0 top priority.
- All outputs are registered; there is no combinational path from `req`/`done` to any output.

## Test plan
- Reset, then `req` = 111 held with `done` pulsed every 2nd grant cycle → `sel` sequence 00,01,10,00…, `gnt` 001,010,100,001, no idle cycles between grants.
- `req` = 010 for 20 cycles, `MAX_HOLD` = 8 → `gnt` = 010 continuously, `sel` = 01, `hold_cnt` wraps 8→1 twice; then `req` = 000 → `gnt` = 000, `sel` stays 01.
- `req` = 011 constant, no `done` → `gnt` alternates 001/010 every 8 cycles; each owner holds exactly 8 cycles.
- `req` = 100 granted, then `req` = 101 with `done` = 1 on one edge → `gnt` = 001 next cycle, and `ptr` = 0 afterwards.
- `rst_n` pulsed low mid-grant of source 2 → `gnt` = 000, `sel` = 00, `gnt_valid` = 0 before the next edge; after release with `req` = 110 → `gnt` = 010.
- Random `req`/`done` for 10k cycles → `sel` never 11, `gnt` always one-hot or zero, no requester starved beyond 2·`MAX_HOLD` + 2 cycles.

Source files
------------

// File: rtl/arb3_mux_sel.sv
// arb3_mux_sel: registered round-robin arbiter for three requesters that also
// produces the 2-bit select for a downstream 3:1 mux (00=a, 01=b, 10=c).
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req[2:0]  in   request per source, bit i = source i
//   done      in   owner finished; releases the grant at the next edge
//   gnt[2:0]  out  registered one-hot grant, zero when idle
//   gnt_valid out  registered, equals |gnt
//   sel[1:0]  out  registered index of the current owner; holds while idle
//   hold_cnt  out  registered count of cycles the owner has held (debug)
//
// MAX_HOLD (1..255) bounds how long one owner keeps the grant while any other
// source is requesting.
module arb3_mux_sel #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] sel,
  output logic [7:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_d;
  logic [2:0] gnt_d;
  logic [7:0] hold_d;
  logic [2:0] owner_oh;
  logic       others, rel;
  logic [1:0] scan_ptr;
  logic [2:0] scan_req;
  logic [2:0] pick;      // {found, idx}

  // First set bit of r scanning p, p+1, p+2 (mod 3). An illegal pointer
  // finds nothing so the block falls back to a clean state.
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [2:0] res;
    res = 3'b000;
    unique case (p)
      2'd0: begin
        if      (r[0]) res = 3'b100;
        else if (r[1]) res = 3'b101;
        else if (r[2]) res = 3'b110;
      end
      2'd1: begin
        if      (r[1]) res = 3'b101;
        else if (r[2]) res = 3'b110;
        else if (r[0]) res = 3'b100;
      end
      2'd2: begin
        if      (r[2]) res = 3'b110;
        else if (r[0]) res = 3'b100;
        else if (r[1]) res = 3'b101;
      end
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel;
    gnt_d    = gnt;
    hold_d   = hold_cnt;

    // In GRANT, sel is the owner index.
    owner_oh = 3'b001 << sel;
    others   = |(req & ~owner_oh);
    rel      = ~|(req & owner_oh) | done | ((hold_cnt >= HOLD_LIM) & others);

    // On release the pointer moves past the owner and the owner is masked,
    // so re-arbitration in the same edge hands off without a bubble.
    scan_ptr = ptr_q;
    scan_req = req;
    if (state_q == GRANT && rel) begin
      scan_ptr = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      scan_req = req & ~owner_oh;
    end
    pick = rr_pick(scan_ptr, scan_req);

    unique case (state_q)
      IDLE: begin
        if (pick[2]) begin
          state_d = GRANT;
          gnt_d   = 3'b001 << pick[1:0];
          sel_d   = pick[1:0];
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = scan_ptr;
          if (pick[2]) begin
            gnt_d  = 3'b001 << pick[1:0];
            sel_d  = pick[1:0];
            hold_d = 8'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            hold_d  = 8'd0;
          end
        end else if (hold_cnt >= HOLD_LIM) begin
          // Limit reached with nobody waiting: keep the grant, restart count.
          hold_d = 8'd1;
        end else if (hold_cnt != 8'hff) begin
          hold_d = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        hold_d  = 8'd0;
      end
    endcase

    // An illegal index (11) recovers to source 0 at the next edge.
    if (ptr_d == 2'b11) ptr_d = 2'd0;
    if (sel_d == 2'b11) sel_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      sel       <= 2'd0;
      gnt       <= 3'b000;
      gnt_valid <= 1'b0;
      hold_cnt  <= 8'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel       <= sel_d;
      gnt       <= gnt_d;
      gnt_valid <= |gnt_d;
      hold_cnt  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (sel != 2'b11);
      assert ($countones(gnt) <= 1);
    end
  end

endmodule

// File: tb/tb_arb3_mux_sel.sv
module tb_arb3_mux_sel;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] sel;
  logic [7:0] hold_cnt;

  arb3_mux_sel #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .sel(sel), .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [7:0] hold;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model state: owner index (-1 = idle), sel, pointer, hold count.
  int m_own, m_sel, m_ptr, m_hold;
  int wt[3];
  int maxw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input int p, input logic [2:0] r);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
    for (int i = 0; i < 3; i++) wt[i] = 0;
  endtask

  task automatic model_step(input logic [2:0] r, input logic d);
    int w;
    logic [2:0] mr;
    if (m_own < 0) begin
      w = scan(m_ptr, r);
      if (w >= 0) begin m_own = w; m_sel = w; m_hold = 1; end
    end else begin
      mr = r;
      mr[m_own] = 1'b0;
      if (!r[m_own] || d || (m_hold >= 8 && mr != 3'b000)) begin
        m_ptr = (m_own + 1) % 3;
        w = scan(m_ptr, mr);
        if (w >= 0) begin m_own = w; m_sel = w; m_hold = 1; end
        else begin m_own = -1; m_hold = 0; end
      end else if (m_hold >= 8) m_hold = 1;
      else if (m_hold < 255) m_hold = m_hold + 1;
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input logic [2:0] r, input logic d);
    exp_t e;
    req = r; done = d;
    model_step(r, d);
    e.gnt  = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
    e.sel  = 2'(m_sel);
    e.hold = 8'(m_hold);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gnt", gnt, e.gnt);
    chk("gnt_valid", gnt_valid, |e.gnt);
    chk("sel", sel, e.sel);
    chk("hold_cnt", hold_cnt, e.hold);
    for (int i = 0; i < 3; i++) begin
      if (r[i] && !gnt[i]) wt[i]++; else wt[i] = 0;
      if (wt[i] > maxw) maxw = wt[i];
    end
  endtask

  initial begin
    logic [1:0] exp_sel [4];
    logic [2:0] rr;
    rst_n = 1'b0; req = 3'b000; done = 1'b0;
    maxw = 0;
    model_reset();
    #3;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_valid", gnt_valid, 1'b0);
    chk("rst_sel", sel, 2'b00);
    chk("rst_hold", hold_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesting, done every second grant cycle: 0,1,2,0 rotation.
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0; exp_sel[3] = 2'd1;
    step(3'b111, 1'b0);
    chk("rr_first_gnt", gnt, 3'b001);
    for (int k = 0; k < 4; k++) begin
      step(3'b111, 1'b1);
      chk("rr_sel_seq", sel, exp_sel[k]);
      step(3'b111, 1'b0);
    end
    step(3'b000, 1'b0);
    chk("idle_gnt", gnt, 3'b000);

    // Lone requester: keeps the grant, hold count wraps 8 -> 1.
    for (int k = 0; k < 20; k++) step(3'b010, 1'b0);
    chk("lone_gnt", gnt, 3'b010);
    chk("lone_hold", hold_cnt, 8'd4);
    step(3'b000, 1'b0);
    chk("lone_release_gnt", gnt, 3'b000);
    chk("lone_release_sel", sel, 2'b01);

    // Two constant requesters: hold-limit preemption every 8 cycles.
    for (int k = 0; k < 8; k++) step(3'b011, 1'b0);
    chk("pre_owner0_8", gnt, 3'b001);
    chk("pre_hold8", hold_cnt, 8'd8);
    step(3'b011, 1'b0);
    chk("pre_owner1", gnt, 3'b010);
    for (int k = 0; k < 8; k++) step(3'b011, 1'b0);
    chk("pre_back_to0", gnt, 3'b001);
    step(3'b000, 1'b0);

    // Source 2 granted, then done with source 0 also requesting.
    step(3'b100, 1'b0);
    chk("s2_gnt", gnt, 3'b100);
    step(3'b101, 1'b1);
    chk("done_handoff", gnt, 3'b001);
    step(3'b000, 1'b0);

    // Asynchronous reset in the middle of a source-2 grant.
    step(3'b100, 1'b0);
    step(3'b100, 1'b0);
    chk("mid_gnt", gnt, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 3'b000);
    chk("arst_sel", sel, 2'b00);
    chk("arst_valid", gnt_valid, 1'b0);
    chk("arst_hold", hold_cnt, 8'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(3'b110, 1'b0);
    chk("post_rst_gnt", gnt, 3'b010);

    // Random traffic, biased toward requests being held.
    maxw = 0;
    for (int k = 0; k < 10000; k++) begin
      rr[0] = ($urandom_range(0, 3) != 0);
      rr[1] = ($urandom_range(0, 3) != 0);
      rr[2] = ($urandom_range(0, 3) != 0);
      step(rr, ($urandom_range(0, 7) == 0));
    end
    chk("starve_bound_ok", (maxw <= 18), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
